poc_printer: RTL
================

# poc_printer

Printer-side endpoint of the POC parallel printer port. Samples a byte on each rising edge of `pulse_request` and queues it in a small FIFO. A print engine then drains the FIFO at a fixed per-character time, emitting each printed character on a one-cycle strobe. `print_ready` tells the POC whether another byte can be accepted. The block serves as the printer model in system simulation and as the synthesizable sink on the FPGA board.

## Interface
- `FIFO_DEPTH`, default 4: byte-buffer entries; power of two, ≥2.
- `PRINT_CYCLES`, default 8: clocks spent printing one character; ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `print_data`  in  8  byte from POC; valid while `pulse_request`=1.
- `pulse_request`  in  1  strobe from POC; level high ≥1 cycle per byte.
- `online`  in  1  printer online; 0 stalls printing and deasserts ready.
- `clear_err`  in  1  clears `overrun`.
- `print_ready`  out  1  1 = printer can accept a byte.
- `char_valid`  out  1  one-cycle strobe: `char_out` printed.
- `char_out`  out  8  last printed character.
- `char_count`  out  16  characters printed since reset.
- `overrun`  out  1  sticky: byte arrived while FIFO full.

## Operation
- **Reset:** when `rst_n`=0 at a clock edge, all of the following are cleared:
  - outputs: `print_ready`=0, `char_valid`=0, `char_out`=0, `char_count`=0, `overrun`=0;
  - internals: FIFO empty, engine in IDLE, `pulse_request` edge register=0.
  - A reset mid-print discards the FIFO contents and the current character. No `char_valid` is issued for it.
- **Capture:**
  - The block registers `pulse_request` as `pulse_d`. A capture occurs at a clock edge where `pulse_request`=1 and `pulse_d`=0.
  - A held level yields exactly one capture.
  - If the FIFO is not full, `print_data` is written at that edge. Otherwise the byte is dropped and `overrun` is set.
  - Captures are accepted regardless of `online`.
- **print_ready:** a register loaded every edge with `online` AND (next FIFO count < `FIFO_DEPTH`).
- **Print engine states:**
  - IDLE: if `online`=1 and the FIFO is non-empty, pop the head into `char_out`, set `cnt`=`PRINT_CYCLES`−1, and go to PRINT. Otherwise stay in IDLE.
  - PRINT: if `cnt`≠0, decrement `cnt`. If `cnt`=0, go to IDLE with `char_valid`=1 for the next cycle.
  - `online` falling during PRINT does not abort the current character. It only blocks the next pop.
- **Simultaneous push and pop:** the FIFO count is unchanged and both operations take effect.
  - A pop never returns the byte written at the same edge when the FIFO was empty. That byte is popped at a later edge.
- **Counter and flags:**
  - `char_count` increments on each `char_valid` and wraps 0xFFFF→0x0000.
  - `overrun`: a set on the same edge as `clear_err`=1 wins (stays 1). Otherwise `clear_err` clears it.
- `char_out` holds its value between characters.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `print_ready` rises on the first edge after `rst_n` returns high, provided `online`=1.
- **Capture → `print_ready`:** the capture that fills the FIFO drops `print_ready` at that same edge.
  - A POC checking `print_ready` after its 2-cycle pulse therefore sees 0.
- **Capture → `char_valid`** (empty FIFO, engine IDLE, `online`=1):
  - capture at edge c;
  - pop at edge c+1;
  - `char_valid`=1 after edge c+1+`PRINT_CYCLES`.
  - With the default of 8, `char_valid` is high in the cycle following edge c+9.
- **Throughput:** one character per `PRINT_CYCLES`+1 clocks when the FIFO is continuously non-empty.
- **Pop → `print_ready`:** a pop from a full FIFO raises `print_ready` at the pop edge.

## Test plan
- **Single byte:** reset, `online`=1, pulse 0x41 for 2 cycles → one `char_valid` 9 cycles after capture with `char_out`=0x41, `char_count`=1, `print_ready` stays 1.
- **Held pulse:** `pulse_request` held high 20 cycles with data 0x55 → exactly one char 0x55 printed, `char_count`=1.
- **Full FIFO:**
  - 5 back-to-back pulses (0x01..0x05, 2 cycles high, 1 low) with `online`=0 → `print_ready`=0 after the 4th capture, `overrun`=1, and 0x05 is lost;
  - then `online`=1 → 0x01..0x04 printed in order at 9-cycle spacing, `char_count`=4.
- **Overrun clear race:** `clear_err`=1 on the same edge as an overrun capture → `overrun` stays 1; `clear_err` alone on the next cycle → 0.
- **Reset mid-print:** 3 bytes queued, `rst_n`=0 for 1 edge during PRINT → no `char_valid`, `char_count`=0, FIFO empty, `print_ready`=1 one edge after release.
- **Counter wrap:** force `char_count`=0xFFFF (or print 65536 characters with `PRINT_CYCLES`=1) → the next character gives 0x0000.

Source files
------------

// File: rtl/poc_printer.sv
// poc_printer: printer-side endpoint of the POC parallel printer port.
// Captures a byte on each rising edge of pulse_request into a small FIFO;
// a print engine drains the FIFO, spending PRINT_CYCLES clocks per character
// and flagging each printed character with a one-cycle char_valid strobe.
//
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   print_data    byte from POC, valid while pulse_request is high
//   pulse_request strobe from POC; one capture per rising edge
//   online        printer online; 0 stalls printing and deasserts print_ready
//   clear_err     clears the sticky overrun flag
//   print_ready   1 = another byte can be accepted
//   char_valid    one-cycle strobe: char_out has just been printed
//   char_out      last printed character (held between characters)
//   char_count    characters printed since reset (wraps)
//   overrun       sticky: a byte arrived while the FIFO was full
module poc_printer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRINT_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  print_data,
  input  logic        pulse_request,
  input  logic        online,
  input  logic        clear_err,
  output logic        print_ready,
  output logic        char_valid,
  output logic [7:0]  char_out,
  output logic [15:0] char_count,
  output logic        overrun
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    PRINT = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [TW-1:0]   cnt, cnt_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            pulse_d;
  logic            capture, full, push, pop, done;

  // Rising edge of the POC strobe; a held level captures only once.
  assign capture = pulse_request & ~pulse_d;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = capture & ~full;
  // Pop looks at the pre-edge count, so a byte written into an empty FIFO
  // on this edge is never popped on the same edge.
  assign pop     = (state == IDLE) & online & (count != '0);

  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) begin
          state_next = PRINT;
          cnt_next   = TW'(PRINT_CYCLES - 1);
        end
      end
      PRINT: begin
        if (cnt != '0) begin
          cnt_next = cnt - TW'(1);
        end else begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pulse_d     <= 1'b0;
      print_ready <= 1'b0;
      char_valid  <= 1'b0;
      char_out    <= 8'h00;
      char_count  <= 16'h0000;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pulse_d     <= pulse_request;
      count       <= count_next;
      print_ready <= online & (count_next < CW'(FIFO_DEPTH));
      char_valid  <= done;
      if (done) char_count <= char_count + 16'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        char_out <= mem[rd_ptr];
      end
      // A new overrun on the same edge as clear_err wins.
      if (capture & full) overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= print_data;
  end

endmodule
